// File: rtl/ring_pkg.sv
// Shared types and helpers for the one-hot ring decoder/monitor.
// Latency: n/a (package: types, constants and pure functions only).
// Backpressure: n/a.
//
// Contents:
//   RING_MAX_W   - widest ring the helpers accept; callers zero-extend into it
//   ring_state_t - monitor FSM states (HUNT, VERIFY, LOCKED)
//   rot_next()   - fixed ring rotation, bit k moves to bit k-1, bit 0 wraps to bit n-1
//   is_onehot()  - true when exactly one bit of the word is set
package ring_pkg;

   localparam int RING_MAX_W = 64;

   typedef enum logic [1:0] {
      HUNT   = 2'd0,
      VERIFY = 2'd1,
      LOCKED = 2'd2
   } ring_state_t;

   // Rotation toward bit 0 within an n-bit ring held in the low bits of cur.
   // Bits at or above n are returned as zero.
   function automatic logic [RING_MAX_W-1:0] rot_next(
      input logic [RING_MAX_W-1:0] cur,
      input int                    n
   );
      logic [RING_MAX_W-1:0] nxt;
      nxt = '0;
      for (int i = 0; i < RING_MAX_W-1; i++) begin
         if (i < n-1) begin
            nxt[i] = cur[i+1];
         end
      end
      for (int i = 0; i < RING_MAX_W; i++) begin
         if (i == n-1) begin
            nxt[i] = cur[0];
         end
      end
      return nxt;
   endfunction

   // Clearing the lowest set bit leaves zero only when at most one bit was set;
   // the non-zero test rules out the empty word.
   function automatic logic is_onehot(input logic [RING_MAX_W-1:0] v);
      return (v != '0) && ((v & (v - 1'b1)) == '0);
   endfunction

endpackage

// File: rtl/onehot_to_bin.sv
// One-hot to binary index decoder with a legality flag.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of the input word.
//
// Ports:
//   i_vec   [N]  word to decode
//   o_idx   [IW] position of the set bit; only meaningful when o_legal=1
//   o_legal      exactly one bit of i_vec is set
module onehot_to_bin
   import ring_pkg::*;
#(
   parameter int N  = 4,
   parameter int IW = $clog2(N)
) (
   input  logic [N-1:0]  i_vec,
   output logic [IW-1:0] o_idx,
   output logic          o_legal
);

   // OR of the positions of all set bits: exact for a legal word, and cheap
   // because the result of an illegal word is discarded by the caller.
   always_comb begin
      o_idx = '0;
      for (int i = 0; i < N; i++) begin
         if (i_vec[i]) begin
            o_idx = o_idx | IW'(i);
         end
      end
   end

   assign o_legal = is_onehot(RING_MAX_W'(i_vec));

endmodule

// File: rtl/ring_dec_mon.sv
// Ring decoder + protocol monitor: decodes a rotating one-hot word, locks onto the rotation, counts laps and errors.
// Latency: all outputs registered, valid one cycle after a ring_en=1 sample.
// Backpressure: none; ring_en=0 freezes all state and keeps seq_err low.
//
// Ports:
//   clk, rst    clock and synchronous active-high reset
//   ring_in[N]  observed ring state, sampled when ring_en=1
//   ring_en     sample strobe
//   idx[IW]     index of the last legal sample
//   onehot_ok   last sample had exactly one bit set
//   locked      monitor is in LOCKED
//   seq_err     one-cycle pulse on a rotation/legality error while locked
//   lap_cnt[CW] completed rotations while locked (saturating)
//   err_cnt[CW] seq_err pulses seen (saturating)
// Optional (RING_ERR_STICKY_EN):
//   err_clr     clears err_sticky; a simultaneous seq_err takes priority
//   err_sticky  latched seq_err
module ring_dec_mon
   import ring_pkg::*;
#(
   parameter int N        = 4,
   parameter int IW       = $clog2(N),
   parameter int LOCK_CNT = 2,
   parameter int CW       = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [N-1:0]  ring_in,
   input  logic          ring_en,
`ifdef RING_ERR_STICKY_EN
   input  logic          err_clr,
   output logic          err_sticky,
`endif
   output logic [IW-1:0] idx,
   output logic          onehot_ok,
   output logic          locked,
   output logic          seq_err,
   output logic [CW-1:0] lap_cnt,
   output logic [CW-1:0] err_cnt
);

   localparam int MW = $clog2(LOCK_CNT + 1);
   localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

   ring_state_t   r_state;
   logic [N-1:0]  r_expected;
   logic [MW-1:0] r_match;
   logic [IW-1:0] r_idx;
   logic          r_ok;
   logic          r_seq_err;
   logic [CW-1:0] r_lap;
   logic [CW-1:0] r_err;

   ring_state_t   w_state_nxt;
   logic [N-1:0]  w_expected_nxt;
   logic [MW-1:0] w_match_nxt;
   logic [IW-1:0] w_idx_nxt;
   logic          w_ok_nxt;
   logic          w_seq_err_nxt;
   logic [CW-1:0] w_lap_nxt;
   logic [CW-1:0] w_err_nxt;

   logic [IW-1:0] w_dec_idx;
   logic          w_legal;
   logic [N-1:0]  w_rot;
   logic          w_hit;
   logic [MW-1:0] w_match_inc;

   onehot_to_bin #(
      .N  (N),
      .IW (IW)
   ) u_dec (
      .i_vec   (ring_in),
      .o_idx   (w_dec_idx),
      .o_legal (w_legal)
   );

   // Successor of the current sample; becomes the next expected word on a hit.
   assign w_rot       = N'(rot_next(RING_MAX_W'(ring_in), N));
   assign w_hit       = w_legal && (ring_in == r_expected);
   assign w_match_inc = r_match + 1'b1;

   always_comb begin
      w_state_nxt    = r_state;
      w_expected_nxt = r_expected;
      w_match_nxt    = r_match;
      w_idx_nxt      = r_idx;
      w_ok_nxt       = r_ok;
      w_seq_err_nxt  = 1'b0;
      w_lap_nxt      = r_lap;
      w_err_nxt      = r_err;

      if (ring_en) begin
         w_ok_nxt = w_legal;
         if (w_legal) begin
            w_idx_nxt = w_dec_idx;
         end

         case (r_state)
            HUNT: begin
               if (w_legal) begin
                  w_expected_nxt = w_rot;
                  w_match_nxt    = '0;
                  w_state_nxt    = VERIFY;
               end
            end

            VERIFY: begin
               if (w_hit) begin
                  w_expected_nxt = w_rot;
                  w_match_nxt    = w_match_inc;
                  if (w_match_inc == MW'(LOCK_CNT)) begin
                     w_state_nxt = LOCKED;
                  end
               end else begin
                  // Not yet trusted: drop back silently.
                  w_match_nxt = '0;
                  w_state_nxt = HUNT;
               end
            end

            LOCKED: begin
               if (w_hit) begin
                  w_expected_nxt = w_rot;
                  // A hit landing on bit N-1 can only have come from bit 0: one full lap.
                  if (ring_in[N-1] && (r_lap != CNT_MAX)) begin
                     w_lap_nxt = r_lap + 1'b1;
                  end
               end else begin
                  // Stalls, skips and illegal words all land here.
                  w_seq_err_nxt = 1'b1;
                  if (r_err != CNT_MAX) begin
                     w_err_nxt = r_err + 1'b1;
                  end
                  w_match_nxt = '0;
                  w_state_nxt = HUNT;
               end
            end

            default: begin
               w_state_nxt = HUNT;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= HUNT;
         r_expected <= '0;
         r_match    <= '0;
         r_idx      <= '0;
         r_ok       <= 1'b0;
         r_seq_err  <= 1'b0;
         r_lap      <= '0;
         r_err      <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_expected <= w_expected_nxt;
         r_match    <= w_match_nxt;
         r_idx      <= w_idx_nxt;
         r_ok       <= w_ok_nxt;
         r_seq_err  <= w_seq_err_nxt;
         r_lap      <= w_lap_nxt;
         r_err      <= w_err_nxt;
      end
   end

   assign idx       = r_idx;
   assign onehot_ok = r_ok;
   assign locked    = (r_state == LOCKED);
   assign seq_err   = r_seq_err;
   assign lap_cnt   = r_lap;
   assign err_cnt   = r_err;

`ifdef RING_ERR_STICKY_EN
   logic r_err_sticky;

   // Set has priority so an error coinciding with a clear is never lost.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_err_sticky <= 1'b0;
      end else if (w_seq_err_nxt) begin
         r_err_sticky <= 1'b1;
      end else if (err_clr) begin
         r_err_sticky <= 1'b0;
      end
   end

   assign err_sticky = r_err_sticky;
`endif

endmodule
